alu_arbiter: RTL and testbench

Shares the single combinational RV32 ALU between two requesters: requester 0 (execute stage) and requester 1 (load/store address generation). Each cycle the block picks at most one request and drives it onto the ALU inputs. The ALU result and its five compare flags are captured into a one-entry output register, which carries the requester ID and uses a valid/ready handshake toward the writeback/AGU consumer.

---
 rtl/alu_arbiter_if.sv | 58 +++++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the ALU arbiter, its two requesters, the shared ALU and the result consumer.
interface alu_arbiter_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned FLAG_W = 5;

  // requester side
  logic              req0_w_i_h;
  logic              req1_w_i_h;
  logic [XLEN-1:0]   a0_w_i;
  logic [XLEN-1:0]   b0_w_i;
  logic [XLEN-1:0]   a1_w_i;
  logic [XLEN-1:0]   b1_w_i;
  logic [CTRL_W-1:0] ctrl0_w_i;
  logic [CTRL_W-1:0] ctrl1_w_i;
  logic              sub0_w_i;
  logic              sub1_w_i;
  logic              fadd0_w_i;
  logic              fadd1_w_i;
  logic              gnt0_w_o_h;
  logic              gnt1_w_o_h;

  // shared ALU side
  logic [XLEN-1:0]   alu_a_w_o;
  logic [XLEN-1:0]   alu_b_w_o;
  logic [CTRL_W-1:0] alu_ctrl_w_o;
  logic              alu_sub_w_o;
  logic              alu_fadd_w_o;
  logic [XLEN-1:0]   alu_res_w_i;
  logic [FLAG_W-1:0] alu_flags_w_i;

  // result consumer side
  logic              res_valid_w_o_h;
  logic              res_ready_w_i_h;
  logic [XLEN-1:0]   res_data_w_o;
  logic [FLAG_W-1:0] res_flags_w_o;
  logic              res_id_w_o;

  modport slave (
    input  req0_w_i_h, req1_w_i_h, a0_w_i, b0_w_i, a1_w_i, b1_w_i,
    input  ctrl0_w_i, ctrl1_w_i, sub0_w_i, sub1_w_i, fadd0_w_i, fadd1_w_i,
    output gnt0_w_o_h, gnt1_w_o_h,
    output alu_a_w_o, alu_b_w_o, alu_ctrl_w_o, alu_sub_w_o, alu_fadd_w_o,
    input  alu_res_w_i, alu_flags_w_i,
    output res_valid_w_o_h, res_data_w_o, res_flags_w_o, res_id_w_o,
    input  res_ready_w_i_h
  );

  modport master (
    output req0_w_i_h, req1_w_i_h, a0_w_i, b0_w_i, a1_w_i, b1_w_i,
    output ctrl0_w_i, ctrl1_w_i, sub0_w_i, sub1_w_i, fadd0_w_i, fadd1_w_i,
    input  gnt0_w_o_h, gnt1_w_o_h,
    input  alu_a_w_o, alu_b_w_o, alu_ctrl_w_o, alu_sub_w_o, alu_fadd_w_o,
    output alu_res_w_i, alu_flags_w_i,
    input  res_valid_w_o_h, res_data_w_o, res_flags_w_o, res_id_w_o,
    output res_ready_w_i_h
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (0) and the AGU (1);
// the chosen result is captured in a one-entry valid/ready output register.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk_w_i,
  input  logic          rst_w_i_l,
  alu_arbiter_if.slave  bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned FLAG_W = 5;

  logic              res_valid_q, res_valid_d;
  logic [XLEN-1:0]   res_data_q,  res_data_d;
  logic [FLAG_W-1:0] res_flags_q, res_flags_d;
  logic              res_id_q,    res_id_d;
  logic              last_q,      last_d;

  logic out_free;
  logic gnt0, gnt1, gnt_any;

  // Arbitration: grant only into a free output slot; ties go by priority mode
  always_comb begin
    out_free = ~res_valid_q | bus.res_ready_w_i_h;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (out_free && rst_w_i_l) begin
      if (bus.req0_w_i_h && bus.req1_w_i_h) begin
        if (FIXED_PRIO || last_q) gnt0 = 1'b1;
        else                      gnt1 = 1'b1;
      end else if (bus.req0_w_i_h) begin
        gnt0 = 1'b1;
      end else if (bus.req1_w_i_h) begin
        gnt1 = 1'b1;
      end
    end
    gnt_any = gnt0 | gnt1;
  end

  // ALU input mux; idle cycles present all-zero inputs so the ALU stays on a defined arm
  always_comb begin
    bus.alu_a_w_o    = '0;
    bus.alu_b_w_o    = '0;
    bus.alu_ctrl_w_o = '0;
    bus.alu_sub_w_o  = 1'b0;
    bus.alu_fadd_w_o = 1'b0;
    if (gnt0) begin
      bus.alu_a_w_o    = bus.a0_w_i;
      bus.alu_b_w_o    = bus.b0_w_i;
      bus.alu_ctrl_w_o = bus.ctrl0_w_i;
      bus.alu_sub_w_o  = bus.sub0_w_i;
      bus.alu_fadd_w_o = bus.fadd0_w_i;
    end else if (gnt1) begin
      bus.alu_a_w_o    = bus.a1_w_i;
      bus.alu_b_w_o    = bus.b1_w_i;
      bus.alu_ctrl_w_o = bus.ctrl1_w_i;
      bus.alu_sub_w_o  = bus.sub1_w_i;
      bus.alu_fadd_w_o = bus.fadd1_w_i;
    end
  end

  // Next state of the output register and the round-robin pointer
  always_comb begin
    res_valid_d = res_valid_q & ~bus.res_ready_w_i_h;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_id_d    = res_id_q;
    last_d      = last_q;
    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.alu_res_w_i;
      res_flags_d = bus.alu_flags_w_i;
      res_id_d    = gnt1;
      last_d      = gnt1;
    end
  end

  // State register; last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_id_q    <= res_id_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt0_w_o_h      = gnt0;
  assign bus.gnt1_w_o_h      = gnt1;
  assign bus.res_valid_w_o_h = res_valid_q;
  assign bus.res_data_w_o    = res_data_q;
  assign bus.res_flags_w_o   = res_flags_q;
  assign bus.res_id_w_o      = res_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter, round-robin and fixed-priority builds side by side.
module tb_alu_arbiter;
  logic clk;
  logic rst_n;

  logic        req   [2];
  logic [31:0] op_a  [2];
  logic [31:0] op_b  [2];
  logic [3:0]  op_c  [2];
  logic        op_s  [2];
  logic        op_f  [2];
  logic        ready;

  // reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic [4:0]  m_flags [2];
  logic        m_id    [2];
  logic        m_last  [2];
  logic        g_any   [2];
  int          g_w     [2];

  int n_tests;
  int n_fail;

  alu_arbiter_if if_rr ();
  alu_arbiter_if if_fp ();

  alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk_w_i(clk), .rst_w_i_l(rst_n), .bus(if_rr.slave));
  alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk_w_i(clk), .rst_w_i_l(rst_n), .bus(if_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub of the shared ALU used to close the loop
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c, input logic s, input logic f);
    if (f) return a + b;
    case (c)
      4'b0000, 4'b1000: return s ? a - b : a + b;
      4'b0010:          return {31'd0, $signed(a) < $signed(b)};
      4'b0011:          return {31'd0, a < b};
      4'b0100:          return a ^ b;
      4'b0110:          return a | b;
      4'b0111:          return a & b;
      default:          return a + b;
    endcase
  endfunction

  function automatic logic [4:0] flag_fn(input logic [31:0] a, input logic [31:0] b);
    return {a == b, a >= b, a < b, $signed(a) >= $signed(b), $signed(a) < $signed(b)};
  endfunction

  assign if_rr.req0_w_i_h = req[0];   assign if_fp.req0_w_i_h = req[0];
  assign if_rr.req1_w_i_h = req[1];   assign if_fp.req1_w_i_h = req[1];
  assign if_rr.a0_w_i = op_a[0];      assign if_fp.a0_w_i = op_a[0];
  assign if_rr.b0_w_i = op_b[0];      assign if_fp.b0_w_i = op_b[0];
  assign if_rr.a1_w_i = op_a[1];      assign if_fp.a1_w_i = op_a[1];
  assign if_rr.b1_w_i = op_b[1];      assign if_fp.b1_w_i = op_b[1];
  assign if_rr.ctrl0_w_i = op_c[0];   assign if_fp.ctrl0_w_i = op_c[0];
  assign if_rr.ctrl1_w_i = op_c[1];   assign if_fp.ctrl1_w_i = op_c[1];
  assign if_rr.sub0_w_i = op_s[0];    assign if_fp.sub0_w_i = op_s[0];
  assign if_rr.sub1_w_i = op_s[1];    assign if_fp.sub1_w_i = op_s[1];
  assign if_rr.fadd0_w_i = op_f[0];   assign if_fp.fadd0_w_i = op_f[0];
  assign if_rr.fadd1_w_i = op_f[1];   assign if_fp.fadd1_w_i = op_f[1];
  assign if_rr.res_ready_w_i_h = ready;
  assign if_fp.res_ready_w_i_h = ready;
  assign if_rr.alu_res_w_i = alu_fn(if_rr.alu_a_w_o, if_rr.alu_b_w_o, if_rr.alu_ctrl_w_o,
                                    if_rr.alu_sub_w_o, if_rr.alu_fadd_w_o);
  assign if_fp.alu_res_w_i = alu_fn(if_fp.alu_a_w_o, if_fp.alu_b_w_o, if_fp.alu_ctrl_w_o,
                                    if_fp.alu_sub_w_o, if_fp.alu_fadd_w_o);
  assign if_rr.alu_flags_w_i = flag_fn(if_rr.alu_a_w_o, if_rr.alu_b_w_o);
  assign if_fp.alu_flags_w_i = flag_fn(if_fp.alu_a_w_o, if_fp.alu_b_w_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_flags[d] = '0; m_id[d] = 1'b0; m_last[d] = 1'b1;
      g_any[d] = 1'b0; g_w[d] = 0;
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the model
  task automatic check_dut(input int d, input string p, input logic g0, input logic g1,
                           input logic [31:0] aa, input logic [31:0] bb, input logic [3:0] cc,
                           input logic ss, input logic ff, input logic v,
                           input logic [31:0] rd, input logic [4:0] rf, input logic ri);
    logic gnt;
    int   w;
    gnt = (!m_valid[d] || ready) && (req[0] || req[1]);
    if (req[0] && req[1]) w = (d == 1) ? 0 : (m_last[d] ? 0 : 1);
    else                  w = req[1] ? 1 : 0;
    check({p, "gnt0"}, 32'(g0), 32'(gnt && w == 0));
    check({p, "gnt1"}, 32'(g1), 32'(gnt && w == 1));
    check({p, "alu_a"}, aa, gnt ? op_a[w] : 32'd0);
    check({p, "alu_b"}, bb, gnt ? op_b[w] : 32'd0);
    check({p, "alu_ctrl"}, 32'(cc), gnt ? 32'(op_c[w]) : 32'd0);
    check({p, "alu_sub"}, 32'(ss), gnt ? 32'(op_s[w]) : 32'd0);
    check({p, "alu_fadd"}, 32'(ff), gnt ? 32'(op_f[w]) : 32'd0);
    check({p, "res_valid"}, 32'(v), 32'(m_valid[d]));
    check({p, "res_data"}, rd, m_data[d]);
    check({p, "res_flags"}, 32'(rf), 32'(m_flags[d]));
    check({p, "res_id"}, 32'(ri), 32'(m_id[d]));
    g_any[d] = gnt;
    g_w[d]   = w;
    if (gnt) begin
      m_data[d]  = alu_fn(op_a[w], op_b[w], op_c[w], op_s[w], op_f[w]);
      m_flags[d] = flag_fn(op_a[w], op_b[w]);
      m_id[d]    = w[0];
      m_last[d]  = w[0];
      m_valid[d] = 1'b1;
    end else if (ready) begin
      m_valid[d] = 1'b0;
    end
  endtask

  // Inputs are set just after a falling edge; check, then advance to the next falling edge
  task automatic tick();
    #1;
    check_dut(0, "rr_", if_rr.gnt0_w_o_h, if_rr.gnt1_w_o_h, if_rr.alu_a_w_o, if_rr.alu_b_w_o,
              if_rr.alu_ctrl_w_o, if_rr.alu_sub_w_o, if_rr.alu_fadd_w_o, if_rr.res_valid_w_o_h,
              if_rr.res_data_w_o, if_rr.res_flags_w_o, if_rr.res_id_w_o);
    check_dut(1, "fp_", if_fp.gnt0_w_o_h, if_fp.gnt1_w_o_h, if_fp.alu_a_w_o, if_fp.alu_b_w_o,
              if_fp.alu_ctrl_w_o, if_fp.alu_sub_w_o, if_fp.alu_fadd_w_o, if_fp.res_valid_w_o_h,
              if_fp.res_data_w_o, if_fp.res_flags_w_o, if_fp.res_id_w_o);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic f);
    req[r] = 1'b1; op_a[r] = a; op_b[r] = b; op_c[r] = c; op_s[r] = s; op_f[r] = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) set_op(r, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    req[0] = 1'b0; req[1] = 1'b0; ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ctrl_list [8];
    logic       pend [2];
    n_tests = 0;
    n_fail  = 0;
    ctrl_list[0] = 4'b0000; ctrl_list[1] = 4'b1000; ctrl_list[2] = 4'b0010; ctrl_list[3] = 4'b0011;
    ctrl_list[4] = 4'b0100; ctrl_list[5] = 4'b0110; ctrl_list[6] = 4'b0111; ctrl_list[7] = 4'b0001;

    // reset state and single request
    do_reset();
    tick();
    ready = 1'b1;
    set_op(0, 32'd5, 32'd7, 4'b0000, 1'b0, 1'b0);
    tick();
    check("single_gnt0", 32'(g_any[0] && g_w[0] == 0), 32'd1);
    req[0] = 1'b0;
    check("single_valid", 32'(if_rr.res_valid_w_o_h), 32'd1);
    check("single_data", if_rr.res_data_w_o, 32'd12);
    check("single_id", 32'(if_rr.res_id_w_o), 32'd0);
    tick();

    // contention: round-robin alternates from 0, fixed priority always 0
    do_reset();
    ready = 1'b1;
    set_op(0, 32'd10, 32'd1, 4'b0000, 1'b0, 1'b0);
    set_op(1, 32'd20, 32'd2, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tie_rr_winner", 32'(g_w[0]), 32'(i % 2));
      check("tie_fp_winner", 32'(g_w[1]), 32'd0);
      check("tie_rr_res_id", 32'(if_rr.res_id_w_o), 32'(i % 2));
    end
    req[0] = 1'b0; req[1] = 1'b0;
    tick();

    // backpressure
    do_reset();
    set_op(0, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0);
    tick();
    req[0] = 1'b0;
    set_op(1, 32'd40, 32'd2, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_grant", 32'(g_any[0]), 32'd0);
      check("bp_data_hold", if_rr.res_data_w_o, 32'd3);
    end
    ready = 1'b1;
    tick();
    check("bp_release_gnt1", 32'(g_any[0] && g_w[0] == 1), 32'd1);
    req[1] = 1'b0;
    check("bp_new_data", if_rr.res_data_w_o, 32'd38);
    check("bp_new_id", 32'(if_rr.res_id_w_o), 32'd1);
    tick();

    // subtract with eq flag, then signed/unsigned compare
    do_reset();
    ready = 1'b1;
    set_op(1, 32'd3, 32'd3, 4'b1000, 1'b1, 1'b0);
    tick();
    check("sub_data", if_rr.res_data_w_o, 32'd0);
    check("sub_eq", 32'(if_rr.res_flags_w_o[4]), 32'd1);
    set_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b0, 1'b0);
    tick();
    req[1] = 1'b0;
    check("cmp_data", if_rr.res_data_w_o, 32'd0);
    check("cmp_ltu", 32'(if_rr.res_flags_w_o[2]), 32'd0);
    check("cmp_lts", 32'(if_rr.res_flags_w_o[0]), 32'd1);
    tick();

    // force-add
    set_op(0, 32'h100, 32'h4, 4'b0100, 1'b0, 1'b1);
    tick();
    req[0] = 1'b0;
    check("fadd_data", if_rr.res_data_w_o, 32'h104);
    tick();

    // reset mid-operation
    do_reset();
    set_op(0, 32'd9, 32'd9, 4'b0000, 1'b0, 1'b0);
    tick();
    set_op(1, 32'd4, 32'd4, 4'b0000, 1'b0, 1'b0);
    check("mid_valid_before", 32'(if_rr.res_valid_w_o_h), 32'd1);
    #2;
    rst_n = 1'b0;
    ready = 1'b1;
    #1;
    check("mid_rr_valid_clr", 32'(if_rr.res_valid_w_o_h), 32'd0);
    check("mid_fp_valid_clr", 32'(if_fp.res_valid_w_o_h), 32'd0);
    check("mid_rr_gnt_in_rst", 32'(if_rr.gnt0_w_o_h | if_rr.gnt1_w_o_h), 32'd0);
    check("mid_fp_gnt_in_rst", 32'(if_fp.gnt0_w_o_h | if_fp.gnt1_w_o_h), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    check("mid_tie_to_0", 32'(g_any[0] && g_w[0] == 0), 32'd1);
    req[0] = 1'b0; req[1] = 1'b0;
    tick();

    // randomized traffic
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[r] = 1'b1;
            set_op(r, $urandom, ($urandom_range(0, 3) == 0) ? op_a[r] : $urandom,
                   ctrl_list[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0));
          end else begin
            req[r] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[r] = 1'b0;
          req[r]  = 1'b0;
        end
      end
      tick();
      if (g_any[0]) begin
        pend[g_w[0]] = 1'b0;
        req[g_w[0]]  = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
